seg7_to_binary_decoder: RTL and testbench

// Receive-side counterpart of the BCD hex driver: takes six 7-segment codes (HEX5..HEX0),

---
 rtl/hex_pkg.sv | 53 +++++
 rtl/bcd_to_binary_seq.sv | 73 +++++++
 rtl/seg7_to_binary_decoder.sv | 136 +++++++++++++
 tb/tb_seg7_to_binary_decoder.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/hex_pkg.sv
// Shared 7-segment definitions for the hex display driver and its receive-side decoder.
// Contents:
//   DECIMAL_DIGITS / OUTPUT_WIDTH  digit count and binary result width
//   SEG_ZERO..SEG_NINE, SEG_BLANK  active-low segment codes, bits {g,f,e,d,c,b,a}
//   digit_e                        decimal digit enum used by the driver
//   state_e                        decoder FSM states
//   seg7_to_digit()                segment code -> {invalid, digit[3:0]}
package hex_pkg;

   localparam int unsigned DECIMAL_DIGITS = 6;
   localparam int unsigned OUTPUT_WIDTH   = 20;

   localparam logic [6:0] SEG_ZERO  = 7'h40;
   localparam logic [6:0] SEG_ONE   = 7'h79;
   localparam logic [6:0] SEG_TWO   = 7'h24;
   localparam logic [6:0] SEG_THREE = 7'h30;
   localparam logic [6:0] SEG_FOUR  = 7'h19;
   localparam logic [6:0] SEG_FIVE  = 7'h12;
   localparam logic [6:0] SEG_SIX   = 7'h02;
   localparam logic [6:0] SEG_SEVEN = 7'h78;
   localparam logic [6:0] SEG_EIGHT = 7'h00;
   localparam logic [6:0] SEG_NINE  = 7'h18;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   typedef enum logic [3:0] {
      DIGIT_0, DIGIT_1, DIGIT_2, DIGIT_3, DIGIT_4,
      DIGIT_5, DIGIT_6, DIGIT_7, DIGIT_8, DIGIT_9
   } digit_e;

   typedef enum logic [2:0] {IDLE, CAPTURE, DECODE, ACCUM, DONE} state_e;

   // Blank decodes as a valid zero so leading-zero suppression round-trips.
   function automatic logic [4:0] seg7_to_digit(input logic [6:0] seg);
      logic [4:0] r;
      r = 5'b1_0000;
      case (seg)
         SEG_ZERO:  r = {1'b0, DIGIT_0};
         SEG_ONE:   r = {1'b0, DIGIT_1};
         SEG_TWO:   r = {1'b0, DIGIT_2};
         SEG_THREE: r = {1'b0, DIGIT_3};
         SEG_FOUR:  r = {1'b0, DIGIT_4};
         SEG_FIVE:  r = {1'b0, DIGIT_5};
         SEG_SIX:   r = {1'b0, DIGIT_6};
         SEG_SEVEN: r = {1'b0, DIGIT_7};
         SEG_EIGHT: r = {1'b0, DIGIT_8};
         SEG_NINE:  r = {1'b0, DIGIT_9};
         SEG_BLANK: r = {1'b0, DIGIT_0};
         default:   r = 5'b1_0000;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/bcd_to_binary_seq.sv
// Iterative BCD-to-binary converter: acc = acc*10 + digit, most significant digit first.
// Ports:
//   MAX10_CLK1_50  clock, rising edge
//   reset          synchronous, active-high
//   start_i        load: acc <= 0, idx <= Digits-1, begin stepping next cycle
//   digits_i       packed BCD digits, digit 0 in [3:0]; must be held while stepping
//   done_o         high during the cycle whose edge folds in the last digit
//   acc_o          accumulator; final value valid the cycle after done_o
module bcd_to_binary_seq #(
   parameter int unsigned Digits = 6,
   parameter int unsigned Width  = 20
) (
   input  logic                  MAX10_CLK1_50,
   input  logic                  reset,
   input  logic                  start_i,
   input  logic [Digits*4-1:0]   digits_i,
   output logic                  done_o,
   output logic [Width-1:0]      acc_o
);

   localparam int unsigned IdxW  = $clog2(Digits);
   localparam int unsigned WideW = Width + 4;

   logic [IdxW-1:0]  idx_q, idx_d;
   logic [Width-1:0] acc_q, acc_d;
   logic             busy_q, busy_d;
   logic [WideW-1:0] acc_wide;
   logic [WideW-1:0] acc_x10;
   logic             unused_acc_hi;

   // x10 as shift-and-add; 4 spare bits so the sum never wraps before truncation.
   always_comb begin
      acc_wide = {4'b0000, acc_q};
      acc_x10  = (acc_wide << 3) + (acc_wide << 1) +
                 WideW'(digits_i[32'(idx_q)*4 +: 4]);
   end

   assign unused_acc_hi = ^acc_x10[WideW-1:Width];

   always_comb begin
      acc_d  = acc_q;
      idx_d  = idx_q;
      busy_d = busy_q;
      if (start_i) begin
         acc_d  = '0;
         idx_d  = IdxW'(Digits - 1);
         busy_d = 1'b1;
      end else if (busy_q) begin
         acc_d = acc_x10[Width-1:0];
         if (idx_q == '0) begin
            busy_d = 1'b0;
         end else begin
            idx_d = idx_q - IdxW'(1);
         end
      end
   end

   always_ff @(posedge MAX10_CLK1_50) begin
      if (reset) begin
         acc_q  <= '0;
         idx_q  <= '0;
         busy_q <= 1'b0;
      end else begin
         acc_q  <= acc_d;
         idx_q  <= idx_d;
         busy_q <= busy_d;
      end
   end

   assign done_o = busy_q && (idx_q == '0);
   assign acc_o  = acc_q;

endmodule

// File: rtl/seg7_to_binary_decoder.sv
// Reads six 7-segment codes (HEX5..HEX0, HEX0 least significant) back into a binary value.
// Ports:
//   MAX10_CLK1_50  50 MHz clock, rising edge
//   reset          synchronous, active-high; aborts a conversion in flight
//   HEX0..HEX5     active-low segment codes {dp,g,f,e,d,c,b,a}; dp ignored
//   start          one-cycle request, accepted only while decoder_ready
//   decoder_ready  idle and accepting start
//   result_valid   one-cycle pulse when binary_out/result_error update
//   result_error   some digit held an unrecognised pattern (held until next result)
//   binary_out     decoded value (0 on error), held between results
module seg7_to_binary_decoder
   import hex_pkg::*;
(
   input  logic                    MAX10_CLK1_50,
   input  logic                    reset,
   input  logic [7:0]              HEX0,
   input  logic [7:0]              HEX1,
   input  logic [7:0]              HEX2,
   input  logic [7:0]              HEX3,
   input  logic [7:0]              HEX4,
   input  logic [7:0]              HEX5,
   input  logic                    start,
   output logic                    decoder_ready,
   output logic                    result_valid,
   output logic                    result_error,
   output logic [OUTPUT_WIDTH-1:0] binary_out
);

   state_e                         state_q, state_d;
   logic [6:0]                     hex_in [DECIMAL_DIGITS];
   logic [6:0]                     seg_q  [DECIMAL_DIGITS];
   logic [6:0]                     seg_d  [DECIMAL_DIGITS];
   logic [DECIMAL_DIGITS*4-1:0]    digits_q, digits_d;
   logic                           invalid_q, invalid_d;
   logic [OUTPUT_WIDTH-1:0]        out_q, out_d;
   logic                           err_q, err_d;
   logic                           valid_q, valid_d;
   logic                           seq_start;
   logic                           seq_done;
   logic [OUTPUT_WIDTH-1:0]        seq_acc;
   logic [4:0]                     dec;
   logic                           unused_dp;

   assign hex_in[0] = HEX0[6:0];
   assign hex_in[1] = HEX1[6:0];
   assign hex_in[2] = HEX2[6:0];
   assign hex_in[3] = HEX3[6:0];
   assign hex_in[4] = HEX4[6:0];
   assign hex_in[5] = HEX5[6:0];
   assign unused_dp = ^{HEX0[7], HEX1[7], HEX2[7], HEX3[7], HEX4[7], HEX5[7]};

   always_comb begin
      state_d   = state_q;
      seg_d     = seg_q;
      digits_d  = digits_q;
      invalid_d = invalid_q;
      out_d     = out_q;
      err_d     = err_q;
      valid_d   = 1'b0;
      seq_start = 1'b0;
      dec       = '0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               seg_d   = hex_in;
               state_d = CAPTURE;
            end
         end
         CAPTURE: begin
            invalid_d = 1'b0;
            for (int i = 0; i < int'(DECIMAL_DIGITS); i++) begin
               dec                = seg7_to_digit(seg_q[i]);
               digits_d[i*4 +: 4] = dec[3:0];
               invalid_d          = invalid_d | dec[4];
            end
            state_d = DECODE;
         end
         DECODE: begin
            seq_start = 1'b1;
            state_d   = ACCUM;
         end
         ACCUM: begin
            if (seq_done) begin
               state_d = DONE;
            end
         end
         DONE: begin
            out_d   = invalid_q ? '0 : seq_acc;
            err_d   = invalid_q;
            valid_d = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge MAX10_CLK1_50) begin
      if (reset) begin
         state_q   <= IDLE;
         for (int i = 0; i < int'(DECIMAL_DIGITS); i++) begin
            seg_q[i] <= '0;
         end
         digits_q  <= '0;
         invalid_q <= 1'b0;
         out_q     <= '0;
         err_q     <= 1'b0;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         seg_q     <= seg_d;
         digits_q  <= digits_d;
         invalid_q <= invalid_d;
         out_q     <= out_d;
         err_q     <= err_d;
         valid_q   <= valid_d;
      end
   end

   bcd_to_binary_seq #(
      .Digits (DECIMAL_DIGITS),
      .Width  (OUTPUT_WIDTH)
   ) u_seq (
      .MAX10_CLK1_50 (MAX10_CLK1_50),
      .reset         (reset),
      .start_i       (seq_start),
      .digits_i      (digits_q),
      .done_o        (seq_done),
      .acc_o         (seq_acc)
   );

   assign decoder_ready = (state_q == IDLE);
   assign result_valid  = valid_q;
   assign result_error  = err_q;
   assign binary_out    = out_q;

endmodule

// File: tb/tb_seg7_to_binary_decoder.sv
module tb_seg7_to_binary_decoder;

   typedef struct {
      int unsigned val;
      bit          err;
      int unsigned t;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [7:0]  hex [6];
   logic        decoder_ready;
   logic        result_valid;
   logic        result_error;
   logic [19:0] binary_out;

   int unsigned cyc = 0;
   int          vectors = 0;
   int          miscompares = 0;
   exp_t        sb [$];

   seg7_to_binary_decoder dut (
      .MAX10_CLK1_50 (clk),
      .reset         (reset),
      .HEX0          (hex[0]),
      .HEX1          (hex[1]),
      .HEX2          (hex[2]),
      .HEX3          (hex[3]),
      .HEX4          (hex[4]),
      .HEX5          (hex[5]),
      .start         (start),
      .decoder_ready (decoder_ready),
      .result_valid  (result_valid),
      .result_error  (result_error),
      .binary_out    (binary_out)
   );

   always #10 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [6:0] enc(input int unsigned d);
      case (d)
         0: return 7'h40;
         1: return 7'h79;
         2: return 7'h24;
         3: return 7'h30;
         4: return 7'h19;
         5: return 7'h12;
         6: return 7'h02;
         7: return 7'h78;
         8: return 7'h00;
         default: return 7'h18;
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // codes = {HEX5, ..., HEX0}
   task automatic set_hex(input logic [47:0] codes);
      for (int i = 0; i < 6; i++) hex[i] = codes[i*8 +: 8];
   endtask

   // Stand-in for the display driver: optional leading-zero blanking, random dp.
   task automatic load_value(input int unsigned v, input bit blank);
      int unsigned r;
      int unsigned d [6];
      bit          lead;
      r    = v;
      lead = blank;
      for (int i = 0; i < 6; i++) begin
         d[i] = r % 10;
         r    = r / 10;
      end
      for (int i = 5; i >= 0; i--) begin
         if (lead && d[i] == 0 && i != 0) begin
            hex[i] = {1'($urandom_range(0, 1)), 7'h7F};
         end else begin
            lead   = 1'b0;
            hex[i] = {1'($urandom_range(0, 1)), enc(d[i])};
         end
      end
   endtask

   // Drive a start; track=1 pushes the expected result on the scoreboard.
   task automatic start_conv(input int unsigned v, input bit err, input bit track);
      for (int i = 0; i < 40 && !decoder_ready; i++) step();
      check("ready_before_start", 32'(decoder_ready), 32'd1);
      start = 1'b1;
      if (track) sb.push_back('{v, err, cyc + 1});
      step();
      start = 1'b0;
      check("ready_drop", 32'(decoder_ready), 32'd0);
      for (int i = 0; i < 6; i++) hex[i] = 8'($urandom);
   endtask

   task automatic wait_valid(input string tag);
      for (int i = 0; i < 40; i++) begin
         step();
         if (result_valid) break;
      end
      check({tag, "_timeout"}, 32'(result_valid), 32'd1);
   endtask

   // Scoreboard consumer: every result_valid pulse must match the oldest pending request.
   always @(negedge clk) begin
      if (result_valid) begin
         vectors++;
         assert (sb.size() != 0) else begin
            miscompares++;
            $error("FAIL unexpected_valid: observed pulse at cycle %0d expected none", cyc);
         end
         if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            check("binary_out", 32'(binary_out), e.val);
            check("result_error", 32'(result_error), 32'(e.err));
            check("latency", cyc - e.t, 32'd9);
         end
      end
   end

   initial begin
      reset = 1'b1;
      start = 1'b0;
      set_hex(48'h40_40_40_40_40_40);
      step();
      step();
      // start during reset must be ignored
      start = 1'b1;
      step();
      start = 1'b0;
      reset = 1'b0;
      step();
      check("rst_ready", 32'(decoder_ready), 32'd1);
      check("rst_valid", 32'(result_valid), 32'd0);
      check("rst_error", 32'(result_error), 32'd0);
      check("rst_out", 32'(binary_out), 32'd0);

      // all zeros
      set_hex(48'h40_40_40_40_40_40);
      start_conv(0, 1'b0, 1'b1);
      wait_valid("zeros");

      // 123456
      set_hex(48'h79_24_30_19_12_02);
      start_conv(32'h1E240, 1'b0, 1'b1);
      wait_valid("v123456");

      // 999999, dp bits set to check they are ignored
      set_hex(48'h98_98_98_98_98_98);
      start_conv(32'hF423F, 1'b0, 1'b1);
      wait_valid("v999999");

      // blank leading digits + 024
      set_hex(48'h7F_7F_7F_40_24_19);
      start_conv(24, 1'b0, 1'b1);
      wait_valid("blank24");

      // invalid HEX2 then a clean conversion clears the error
      set_hex(48'h79_24_30_2A_12_02);
      start_conv(0, 1'b1, 1'b1);
      wait_valid("invalid");
      check("err_held", 32'(result_error), 32'd1);
      set_hex(48'h40_40_40_40_79_40);
      start_conv(10, 1'b0, 1'b1);
      wait_valid("err_clear");

      // start while busy ignored; start in result_valid cycle accepted
      load_value(314159, 1'b0);
      start_conv(314159, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) step();
      start = 1'b1;
      step();
      start = 1'b0;
      wait_valid("busy_start");
      load_value(271828, 1'b1);
      start_conv(271828, 1'b0, 1'b1);
      wait_valid("back_to_back");
      for (int i = 0; i < 12; i++) step();
      check("no_extra_pulse", 32'(sb.size()), 32'd0);

      // reset sampled at edge T+5 aborts the conversion
      load_value(555555, 1'b0);
      start_conv(555555, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("abort_valid", 32'(result_valid), 32'd0);
      check("abort_error", 32'(result_error), 32'd0);
      check("abort_out", 32'(binary_out), 32'd0);
      check("abort_ready", 32'(decoder_ready), 32'd1);
      for (int i = 0; i < 15; i++) step();

      // loopback through the driver model
      for (int n = 0; n < 1000; n++) begin
         int unsigned v;
         v = $urandom_range(0, 999999);
         load_value(v, 1'($urandom_range(0, 1)));
         start_conv(v, 1'b0, 1'b1);
         wait_valid("loopback");
      end

      step();
      step();
      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
